// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operand width,
// funct3 op encodings and the FSM state type.
package muldiv_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift in a quotient bit.
module muldiv_div_step
  import muldiv_unit_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] remIn,
  input  logic [W-1:0] quoIn,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] remOut,
  output logic [W-1:0] quoOut
);

  logic [W:0]   remShift;
  logic [W-1:0] diff;
  logic         fits;

  always_comb begin
    remShift = {remIn, quoIn[W-1]};
    fits     = remShift >= {1'b0, divisor};
    // When the divisor fits the true difference is below 2^W, so the
    // wrapped low word is exact.
    diff     = remShift[W-1:0] - divisor;
    remOut   = fits ? diff : remShift[W-1:0];
    quoOut   = {quoIn[W-2:0], fits};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: single-cycle multiply, 32-step
// restoring divide, with fast paths for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic [1:0]      dbgState
);
  import muldiv_unit_pkg::*;

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state;
  logic [XLEN-1:0] opA, opB, quo, rem, dvsr, remNext, quoNext;
  logic [2:0]      f3;
  logic [4:0]      rdQ;
  logic [CW-1:0]   cnt;

  logic            accept, inSigned, fastPath;
  logic [XLEN-1:0] magA, magB;

  always_comb begin
    accept   = start_i && !flush_i && (state == S_IDLE || state == S_DONE);
    inSigned = !funct3_i[0];
    magA     = (inSigned && op_a_i[XLEN-1]) ? -op_a_i : op_a_i;
    magB     = (inSigned && op_b_i[XLEN-1]) ? -op_b_i : op_b_i;
    // Multiplies and the special divide cases all finish with MUL timing.
    fastPath = !funct3_i[2] || (op_b_i == '0) ||
               (inSigned && op_a_i == MIN_INT && op_b_i == '1);
  end

  logic                   aSigned, bSigned, negQ, negR;
  logic signed [XLEN:0]   aExt, bExt;
  logic [2*XLEN-1:0]      prod;
  logic [XLEN-1:0]        mulRes, fastRes, quickRes, divRes;

  always_comb begin
    aSigned  = (f3 == F3_MULH) || (f3 == F3_MULHSU);
    bSigned  = (f3 == F3_MULH);
    aExt     = {aSigned & opA[XLEN-1], opA};
    bExt     = {bSigned & opB[XLEN-1], opB};
    prod     = (2*XLEN)'(aExt) * (2*XLEN)'(bExt);
    mulRes   = (f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    if (opB == '0) fastRes = f3[1] ? opA : '1;
    else           fastRes = f3[1] ? '0  : opA;
    quickRes = f3[2] ? fastRes : mulRes;
    negQ     = !f3[0] && (opA[XLEN-1] ^ opB[XLEN-1]);
    negR     = !f3[0] && opA[XLEN-1];
    if (f3[1]) divRes = negR ? -rem : rem;
    else       divRes = negQ ? -quo : quo;
  end

  muldiv_div_step #(.W(XLEN)) u_step (
    .remIn  (rem),
    .quoIn  (quo),
    .divisor(dvsr),
    .remOut (remNext),
    .quoOut (quoNext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
      opA      <= '0;
      opB      <= '0;
      f3       <= '0;
      rdQ      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      cnt      <= '0;
    end else if (flush_i) begin
      state  <= S_IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        S_MUL: begin
          result_o <= quickRes;
          rd_o     <= rdQ;
          state    <= S_DONE;
          busy_o   <= 1'b0;
          done_o   <= 1'b1;
        end
        S_DIV: begin
          if (cnt == CW'(DIV_CYCLES)) begin
            result_o <= divRes;
            rd_o     <= rdQ;
            state    <= S_DONE;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
          end else begin
            rem <= remNext;
            quo <= quoNext;
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (accept) begin
            opA    <= op_a_i;
            opB    <= op_b_i;
            f3     <= funct3_i;
            rdQ    <= rd_i;
            quo    <= magA;
            dvsr   <= magB;
            rem    <= '0;
            cnt    <= '0;
            state  <= fastPath ? S_MUL : S_DIV;
            busy_o <= 1'b1;
            done_o <= 1'b0;
          end else begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
          end
        end
      endcase
    end
  end

  assign dbgState = state;

endmodule
